stream_xor_cipher: RTL
======================

Name: stream_xor_cipher

Overview:
Keystream consumer stage placed directly downstream of the 8-bit LFSR.
- Controls the LFSR: loads its seed, then advances it one step per consumed byte.
- XORs each incoming message byte with the current LFSR byte, producing ciphertext (or plaintext; the operation is symmetric).
- Message length is fixed per job; uses valid/ready handshakes on both data sides.

Parameters:
DATA_W, 8, byte width of data and keystream; must equal the LFSR width.
LEN_W, 8, width of message-length counter; maximum message is 2^LEN_W-1 bytes.

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
start  in  1  one-cycle job request; honoured only in IDLE
seed_in  in  DATA_W  seed captured on accepted start
msg_len  in  LEN_W  byte count captured on accepted start
ks_in  in  DATA_W  current LFSR output (shift_seed)
ks_load  out  1  drives LFSR seed load; high exactly one cycle per job
ks_seed  out  DATA_W  latched seed presented to LFSR seed input
ks_step  out  1  LFSR advance enable; high in the cycle a byte is accepted
in_valid  in  1  input byte valid
in_ready  out  1  block can accept input byte
in_data  in  DATA_W  message byte
out_valid  out  1  output byte valid
out_ready  in  1  sink accepts output byte
out_data  out  DATA_W  in_data XOR ks_in, registered
out_last  out  1  marks final byte of job, qualified by out_valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; outputs ks_load, ks_step, in_ready, out_valid, out_last, busy and done are 0; out_data and ks_seed are 0; counter is 0. Reset mid-job aborts the job and discards any pending output byte.
- FSM states: IDLE, SEED, RUN, DRAIN.
- IDLE: start=1 latches seed_in to ks_seed and msg_len to len_r, clears the counter, and moves to SEED. start in any other state is ignored.
- SEED: ks_load=1 for this single cycle. Next state is RUN, or DRAIN-complete handling if len_r==0.
  - len_r==0: go to IDLE with done=1 in the following cycle. No output bytes, no ks_step.
- RUN:
  - in_ready = (!out_valid || out_ready) && (cnt < len_r).
  - Accept when in_valid && in_ready. On accept:
    - out_data <= in_data ^ ks_in
    - out_valid <= 1
    - ks_step = 1, combinationally in the same cycle
    - cnt increments
    - out_last <= (cnt == len_r-1)
  - Latency from input accept to out_valid is 1 cycle. Sustained throughput is 1 byte/cycle when out_ready is held at 1.
  - Output register holds its value while out_valid && !out_ready. Backpressure drops in_ready the same cycle.
  - Accepting the last byte moves the FSM to DRAIN.
- DRAIN: in_ready=0. When out_valid && out_ready, clear out_valid and out_last, pulse done=1 for one cycle, and go to IDLE.
- Simultaneous accept and output handshake in RUN: new byte replaces old in the same edge; no bubble.
- Counter never wraps: cnt saturates at len_r, and in_ready is 0 once cnt==len_r.
- ks_in is sampled only in accept cycles. The LFSR must present the post-load value in the first RUN cycle.

Optional Feature:
Macro CIPHER_PARITY_EN.
- Defined: adds output port out_parity (1 bit), the even parity (XOR reduction) of out_data. It is registered alongside out_data, holds under backpressure, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package cipher_pkg:
  - state enum cipher_state_t {IDLE, SEED, RUN, DRAIN}
  - default DATA_W / LEN_W constants
  - function parity8
- One sub-module, cipher_out_reg: the output data/valid/last register with ready-based hold, plus the optional parity bit.
- FSM and counter stay in the top-level module.

Test Plan:
- Reset: hold reset=0 for 3 cycles during RUN with out_valid=1 -> after release, out_valid=0, busy=0, in_ready=0, done=0, state IDLE.
- Single byte: start with seed_in=8'h5A and msg_len=1; ks_in=8'hA5; in_data=8'h3C -> ks_load high 1 cycle with ks_seed=8'h5A, then out_data=8'h99 with out_last=1, ks_step pulsed once, done 1 cycle after out handshake.
- Streaming: msg_len=4, in_valid and out_ready held at 1, ks_in sequence 01,02,03,04, data 10,20,30,40 -> outputs 11,22,33,44 on consecutive cycles, out_last only on 44, exactly 4 ks_step pulses.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> out_data stable, in_ready=0, no ks_step; resume yields no loss or duplication.
- Zero length and ignored start: msg_len=0 -> ks_load once, done pulse, no out_valid; start pulse during RUN -> no effect on seed or count.
- CIPHER_PARITY_EN defined: out_data=8'h99 -> out_parity=0; out_data=8'h98 -> out_parity=1.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types, default widths and helpers for the stream XOR cipher.
// Pure declarations: no logic, no latency, no flow control.
// Imported by stream_xor_cipher and cipher_out_reg.
package cipher_pkg;

  localparam int CIPHER_DATA_W = 8;
  localparam int CIPHER_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN,
    DRAIN
  } cipher_state_t;

  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/cipher_out_reg.sv
// Output byte register (data/valid/last, optional parity under CIPHER_PARITY_EN).
// Latency: one cycle from load_vld to out_valid.
// Backpressure: holds contents while out_valid && !out_ready; a load may replace a byte handed off in the same cycle.
module cipher_out_reg
  import cipher_pkg::*;
#(
  parameter int DATA_W = CIPHER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_vld,
  input  logic [DATA_W-1:0] load_dat,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef CIPHER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
`ifdef CIPHER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef CIPHER_PARITY_EN
    parity_d = parity_q;
`endif
    if (load_vld) begin
      valid_d = 1'b1;
      data_d  = load_dat;
      last_d  = load_last;
`ifdef CIPHER_PARITY_EN
      parity_d = parity8(load_dat);
`endif
    end else if (out_ready) begin
      // Data is left in place after hand-off; only the qualifiers clear.
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef CIPHER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef CIPHER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
`ifdef CIPHER_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: rtl/stream_xor_cipher.sv
// XORs message bytes with an external LFSR keystream; optional out_parity under CIPHER_PARITY_EN.
// Latency: one cycle from input accept to out_valid; 1 byte/cycle sustained.
// Backpressure: in_ready drops in the same cycle out_valid && !out_ready; no LFSR step without an accept.
module stream_xor_cipher
  import cipher_pkg::*;
#(
  parameter int DATA_W = CIPHER_DATA_W,
  parameter int LEN_W  = CIPHER_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed_in,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [DATA_W-1:0] ks_in,
  output logic              ks_load,
  output logic [DATA_W-1:0] ks_seed,
  output logic              ks_step,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef CIPHER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  cipher_state_t     state_q, state_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              accept;

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed_in;
          len_d   = msg_len;
          cnt_d   = '0;
          state_d = SEED;
        end
      end
      SEED: begin
        if (len_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        in_ready = (!out_valid || out_ready) && (cnt_q < len_q);
        accept   = in_valid && in_ready;
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ks_load = (state_q == SEED);
  assign ks_seed = seed_q;
  assign ks_step = accept;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  cipher_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load_vld  (accept),
    .load_dat  (in_data ^ ks_in),
    .load_last (cnt_q == len_q - LEN_W'(1)),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef CIPHER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

endmodule
